// File: rtl/opcode_encoder.sv
// Purpose: encode a one-hot instruction-class vector into a 4-bit opcode plus writeback flag, buffer it, and present it to decode.
// Latency: a legal request accepted at edge N is visible at the output during cycle N+1 when the FIFO was empty. Throughput is one per cycle.
// Backpressure: in_ready follows registered occupancy only. stall and out_ready hold the head entry and never reach in_ready combinationally.

// Generic synchronous FIFO used as the instruction buffer.
// Latency: a push at edge N is readable at pop_dat after edge N. A pop at edge N advances the head.
// Backpressure: a push into a full FIFO and a pop from an empty FIFO are both ignored.
module opcode_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop_rdy & ~w_empty;
    // Fullness is judged on the registered count, so a same-cycle pop never opens room for a push.
    assign w_do_push = push_vld & ~w_full;

    // Storage array. Entries are cleared on reset so nothing stale survives a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: push and pop in the same cycle leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_dat = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule

// Top level: one-hot check and encode, illegal-request accounting, and the output handshake.
// Latency: legal request to output takes one edge. err_illegal rises in the cycle after a rejected accept.
// Backpressure: in_ready = registered occupancy below DEPTH, held low during reset. stall masks out_valid and so blocks pops.
module opcode_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       in_valid,
    input  logic [15:0]                op_onehot,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [3:0]                 out_opcode,
    output logic                       out_iswb,
    input  logic                       out_ready,
    output logic                       err_illegal,
    output logic [CNT_W-1:0]           illegal_cnt,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Opcode values. The bit index in op_onehot equals the opcode.
    localparam logic [3:0] OP_ST      = 4'd4;
    localparam logic [3:0] OP_CMP     = 4'd5;
    localparam logic [3:0] OP_UBRANCH = 4'd12;
    localparam logic [3:0] OP_BEQ     = 4'd13;
    localparam logic [3:0] OP_BGT     = 4'd14;

    logic [4:0]       w_ones;
    logic [3:0]       w_opcode;
    logic             w_iswb;
    logic             w_legal;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;
    logic [4:0]       w_head;
    logic [CW-1:0]    w_count;

    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    // Population count and encode in one pass. For a legal request exactly one bit contributes the opcode.
    always_comb begin
        w_ones   = '0;
        w_opcode = '0;
        for (int k = 0; k < 16; k++) begin
            if (op_onehot[k]) begin
                w_ones   = w_ones + 5'd1;
                w_opcode = 4'(k);
            end
        end
    end

    // Stores, compares and branches produce no register result. Everything else writes back.
    always_comb begin
        w_iswb = 1'b1;
        case (w_opcode)
            OP_ST, OP_CMP, OP_UBRANCH, OP_BEQ, OP_BGT: w_iswb = 1'b0;
            default:                                   w_iswb = 1'b1;
        endcase
    end

    assign w_legal    = (w_ones == 5'd1);

    // Gated by reset so nothing is advertised while the block is held in reset.
    assign in_ready   = reset & (w_count < CW'(DEPTH));
    assign w_accept   = in_valid & in_ready;
    assign w_push     = w_accept & w_legal;

    assign w_nonempty = (w_count != '0);
    assign out_valid  = w_nonempty & ~stall;
    assign w_pop      = out_valid & out_ready;

    opcode_fifo #(
        .W     (5),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push_vld (w_push),
        .push_dat ({w_opcode, w_iswb}),
        .pop_rdy  (w_pop),
        .pop_dat  (w_head),
        .count    (w_count)
    );

    // Outputs read as zero whenever nothing is offered, including during stall.
    assign out_opcode = out_valid ? w_head[4:1] : 4'd0;
    assign out_iswb   = out_valid ? w_head[0]   : 1'b0;
    assign fifo_count = w_count;

    // Single-cycle error pulse following each rejected accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_legal;
        end
    end

    // Rejected-request counter saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_accept && !w_legal && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign err_illegal = r_err;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_opcode_encoder.sv
// Purpose: directed self-checking bench for opcode_encoder.
// Latency: checks are taken one time unit after each rising edge or on the falling edge.
// Backpressure: exercises full FIFO, stall, and held requests.
module tb_opcode_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             in_valid;
    logic [15:0]      op_onehot;
    logic             in_ready;
    logic             out_valid;
    logic [3:0]       out_opcode;
    logic             out_iswb;
    logic             out_ready;
    logic             err_illegal;
    logic [CNT_W-1:0] illegal_cnt;
    logic [2:0]       fifo_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] wb_map;
    logic [3:0]  rx_op [$];
    logic        rx_wb [$];

    always #5 clk = ~clk;

    opcode_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .in_valid    (in_valid),
        .op_onehot   (op_onehot),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_opcode  (out_opcode),
        .out_iswb    (out_iswb),
        .out_ready   (out_ready),
        .err_illegal (err_illegal),
        .illegal_cnt (illegal_cnt),
        .fifo_count  (fifo_count)
    );

    // Collects popped entries until n arrive or the cycle budget runs out; drops in_valid once accepted.
    task automatic drain(input int n, input int budget);
        int   cyc;
        logic acc;
        logic pop;
        logic [3:0] h;
        logic hw;
        cyc = 0;
        while (rx_op.size() < n && cyc < budget) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            pop = out_valid & out_ready;
            h   = out_opcode;
            hw  = out_iswb;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            if (pop) begin
                rx_op.push_back(h);
                rx_wb.push_back(hw);
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; in_valid = 1'b0; op_onehot = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL rst_in_ready got %0h want 0", in_ready); end
        n_chk++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
        n_chk++; if (out_opcode !== 4'd0)  begin n_fail++; $display("FAIL rst_out_opcode got %0h want 0", out_opcode); end
        n_chk++; if (fifo_count !== 3'd0)  begin n_fail++; $display("FAIL rst_fifo_count got %0d want 0", fifo_count); end
        n_chk++; if (illegal_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_illegal_cnt got %0d want 0", illegal_cnt); end
        n_chk++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0h want 0", err_illegal); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL rst_release_in_ready got %0h want 1", in_ready); end
    endtask

    task automatic test_all_opcodes();
        logic [3:0] e_op;
        @(posedge clk); #1;
        wb_map = 16'h8FCF;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; op_onehot = 16'd1 << k;
            e_op = 4'(k);
            @(posedge clk); #1;
            n_chk++; if (out_valid !== 1'b1)       begin n_fail++; $display("FAIL seq_valid[%0d] got %0h want 1", k, out_valid); end
            n_chk++; if (out_opcode !== e_op)      begin n_fail++; $display("FAIL seq_opcode[%0d] got %0d want %0d", k, out_opcode, e_op); end
            n_chk++; if (out_iswb !== wb_map[k])   begin n_fail++; $display("FAIL seq_iswb[%0d] got %0h want %0h", k, out_iswb, wb_map[k]); end
            n_chk++; if (fifo_count !== 3'd1)      begin n_fail++; $display("FAIL seq_count[%0d] got %0d want 1", k, fifo_count); end
        end
        in_valid = 1'b0; op_onehot = '0;
        @(posedge clk); #1;
        n_chk++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL seq_empty got %0d want 0", fifo_count); end
        n_chk++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL seq_idle_valid got %0h want 0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; op_onehot = 16'd1 << i;
            @(posedge clk); #1;
            n_chk++; if (fifo_count !== 3'(i + 1)) begin n_fail++; $display("FAIL full_count[%0d] got %0d want %0d", i, fifo_count, i + 1); end
        end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %0h want 0", in_ready); end
        in_valid = 1'b1; op_onehot = 16'h0010;
        repeat (2) begin
            @(posedge clk); #1;
            n_chk++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL held_count got %0d want 4", fifo_count); end
            n_chk++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL held_in_ready got %0h want 0", in_ready); end
            n_chk++; if (out_opcode !== 4'd0) begin n_fail++; $display("FAIL held_head got %0d want 0", out_opcode); end
        end
        out_ready = 1'b1;
        rx_op.delete(); rx_wb.delete();
        drain(5, 20);
        n_chk++; if (rx_op.size() != 5) begin n_fail++; $display("FAIL full_drain_n got %0d want 5", rx_op.size()); end
        for (int i = 0; i < rx_op.size(); i++) begin
            n_chk++; if (rx_op[i] !== 4'(i)) begin n_fail++; $display("FAIL full_drain[%0d] got %0d want %0d", i, rx_op[i], i); end
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL full_after got %0d want 0", fifo_count); end
    endtask

    task automatic test_illegal();
        logic [15:0] ops     [3];
        logic        e_err   [3];
        logic [7:0]  e_cnt   [3];
        logic        e_vld   [3];
        logic [3:0]  e_op    [3];
        logic        e_wb    [3];
        ops   = '{16'h0000, 16'h0101, 16'h0080};
        e_err = '{1'b1, 1'b1, 1'b0};
        e_cnt = '{8'd1, 8'd2, 8'd2};
        e_vld = '{1'b0, 1'b0, 1'b1};
        e_op  = '{4'd0, 4'd0, 4'd7};
        e_wb  = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op_onehot = ops[i];
            @(posedge clk); #1;
            n_chk++; if (err_illegal !== e_err[i]) begin n_fail++; $display("FAIL ill_err[%0d] got %0h want %0h", i, err_illegal, e_err[i]); end
            n_chk++; if (illegal_cnt !== e_cnt[i]) begin n_fail++; $display("FAIL ill_cnt[%0d] got %0d want %0d", i, illegal_cnt, e_cnt[i]); end
            n_chk++; if (out_valid !== e_vld[i])   begin n_fail++; $display("FAIL ill_valid[%0d] got %0h want %0h", i, out_valid, e_vld[i]); end
            n_chk++; if (out_opcode !== e_op[i])   begin n_fail++; $display("FAIL ill_opcode[%0d] got %0d want %0d", i, out_opcode, e_op[i]); end
            n_chk++; if (out_iswb !== e_wb[i])     begin n_fail++; $display("FAIL ill_iswb[%0d] got %0h want %0h", i, out_iswb, e_wb[i]); end
        end
        in_valid = 1'b0; op_onehot = '0;
        @(posedge clk); #1;
        n_chk++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_err_end got %0h want 0", err_illegal); end
        n_chk++; if (illegal_cnt !== 8'd2) begin n_fail++; $display("FAIL ill_cnt_end got %0d want 2", illegal_cnt); end
        n_chk++; if (fifo_count !== 3'd0)  begin n_fail++; $display("FAIL ill_count_end got %0d want 0", fifo_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [3:0] exp_op [3];
        exp_op = '{4'd6, 4'd15, 4'd8};
        out_ready = 1'b0;
        in_valid = 1'b1; op_onehot = 16'h0040;
        @(posedge clk); #1;
        op_onehot = 16'h8000;
        @(posedge clk); #1;
        n_chk++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL stall_pre_count got %0d want 2", fifo_count); end
        stall = 1'b1; out_ready = 1'b1; op_onehot = 16'h0100;
        @(posedge clk); #1;
        in_valid = 1'b0; op_onehot = '0;
        n_chk++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL stall_valid0 got %0h want 0", out_valid); end
        n_chk++; if (out_opcode !== 4'd0) begin n_fail++; $display("FAIL stall_opcode got %0d want 0", out_opcode); end
        n_chk++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL stall_push_count got %0d want 3", fifo_count); end
        for (int c = 1; c < 3; c++) begin
            @(posedge clk); #1;
            n_chk++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL stall_valid[%0d] got %0h want 0", c, out_valid); end
            n_chk++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL stall_count[%0d] got %0d want 3", c, fifo_count); end
        end
        stall = 1'b0;
        rx_op.delete(); rx_wb.delete();
        drain(3, 10);
        n_chk++; if (rx_op.size() != 3) begin n_fail++; $display("FAIL stall_drain_n got %0d want 3", rx_op.size()); end
        for (int i = 0; i < rx_op.size(); i++) begin
            n_chk++; if (rx_op[i] !== exp_op[i]) begin n_fail++; $display("FAIL stall_drain[%0d] got %0d want %0d", i, rx_op[i], exp_op[i]); end
            n_chk++; if (rx_wb[i] !== 1'b1)      begin n_fail++; $display("FAIL stall_wb[%0d] got %0h want 1", i, rx_wb[i]); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op_onehot = 16'd1 << i;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; op_onehot = '0;
        n_chk++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", fifo_count); end
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL mid_valid got %0h want 0", out_valid); end
        n_chk++; if (fifo_count !== 3'd0)  begin n_fail++; $display("FAIL mid_count got %0d want 0", fifo_count); end
        n_chk++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL mid_in_ready got %0h want 0", in_ready); end
        n_chk++; if (illegal_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", illegal_cnt); end
        @(posedge clk); #1;
        reset = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; op_onehot = 16'h0004;
        @(posedge clk); #1;
        in_valid = 1'b0; op_onehot = '0;
        n_chk++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL mid_new_valid got %0h want 1", out_valid); end
        n_chk++; if (out_opcode !== 4'd2) begin n_fail++; $display("FAIL mid_new_opcode got %0d want 2", out_opcode); end
        n_chk++; if (out_iswb !== 1'b1)   begin n_fail++; $display("FAIL mid_new_iswb got %0h want 1", out_iswb); end
        n_chk++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL mid_new_count got %0d want 1", fifo_count); end
        @(posedge clk); #1;
        n_chk++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_stale_count got %0d want 0", fifo_count); end
        n_chk++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_stale_valid got %0h want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        in_valid = 1'b1; op_onehot = 16'h0000;
        repeat (255) @(posedge clk);
        #1;
        n_chk++; if (illegal_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d want 255", illegal_cnt); end
        n_chk++; if (err_illegal !== 1'b1)   begin n_fail++; $display("FAIL sat_err got %0h want 1", err_illegal); end
        @(posedge clk); #1;
        n_chk++; if (illegal_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_256 got %0d want 255", illegal_cnt); end
        @(posedge clk); #1;
        n_chk++; if (illegal_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_257 got %0d want 255", illegal_cnt); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (err_illegal !== 1'b0)   begin n_fail++; $display("FAIL sat_err_end got %0h want 0", err_illegal); end
        n_chk++; if (fifo_count !== 3'd0)    begin n_fail++; $display("FAIL sat_count got %0d want 0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_all_opcodes();
        test_full();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/opcode_encoder.md
Name: opcode_encoder

Overview:
- Inverse of the control unit's decode path: accepts a one-hot operation vector, one bit per instruction class, and encodes it back to the 4-bit opcode.
- Also derives the writeback flag.
- Buffers encoded instructions in a small FIFO and presents them to the decode stage with a valid/ready handshake.
- Sits between the program loader/instruction generator and the control unit; non-one-hot requests are rejected and counted.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- CNT_W, 8, width of the illegal-request counter

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- stall  input  1  pipeline stall; freezes the output side
- in_valid  input  1  one-hot request present
- op_onehot  input  16  bit k set selects opcode k
- in_ready  output  1  encoder can accept a request this cycle
- out_valid  output  1  encoded instruction available
- out_opcode  output  4  encoded opcode
- out_iswb  output  1  writeback flag of out_opcode
- out_ready  input  1  downstream consumes the head entry
- err_illegal  output  1  one-cycle pulse for a rejected request
- illegal_cnt  output  CNT_W  saturating count of rejected requests
- fifo_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Opcode map (bit index = opcode value):
  - ADD=0, SUB=1, MUL=2, LD=3, ST=4, CMP=5, MOV=6, OR=7
  - AND=8, NOT=9, LSL=10, LSR=11, UBRANCH=12, BEQ=13, BGT=14, XOR=15
- iswb = 0 for ST, CMP, UBRANCH, BEQ, BGT; 1 for all other opcodes.
- Reset (reset=0, asynchronous):
  - FIFO flushed; fifo_count=0, out_valid=0, out_opcode=0, out_iswb=0.
  - err_illegal=0, illegal_cnt=0; in_ready=0 while reset is asserted.
  - Reset mid-operation discards all buffered entries.
- in_ready = (fifo_count < DEPTH). No combinational path from out_ready or stall to in_ready.
- Accept: in_valid & in_ready at a rising edge.
- Push and encode:
  - Accepted request with exactly one bit set: write {opcode, iswb} at the tail.
  - Accepted request with zero or ≥2 bits set: nothing pushed.
  - For a rejected request, err_illegal=1 for the following cycle only, and illegal_cnt increments, saturating at 2^CNT_W−1.
- Output:
  - out_valid = (fifo_count != 0) & ~stall.
  - out_opcode/out_iswb show the head entry when out_valid=1, else 0.
- Pop: out_valid & out_ready at a rising edge; head advances. stall=1 blocks pops but not pushes.
- Latency: a request accepted at edge N is visible at the output after edge N (i.e. in cycle N+1) when the FIFO was empty. Throughput is 1 per cycle.
- Simultaneous push and pop: occupancy unchanged; order preserved.
  - Full FIFO with a pop: in_ready is still 0 that cycle (registered decision).
  - Empty FIFO: a push is never bypassed to the output in the same cycle.
- Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH or goes below 0.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset, then push bits 0..15 in order, out_ready=1, stall=0 → out_opcode sequence 0..15 each one cycle after accept. out_iswb = 1 except opcodes 4, 5, 12, 13, 14 (=0).
- out_ready=0, push 5 legal requests (ADD, SUB, MUL, LD, ST) → in_ready drops after 4 accepts, fifo_count=4, fifth request held. Raise out_ready → 0,1,2,3 drain, then the held request is accepted and delivers opcode 3?? Correction: the held request is ST, so it delivers opcode 4 last.
- Requests op_onehot=16'h0000, then 16'h0101, then 16'h0080 → two err_illegal pulses, illegal_cnt=2, only opcode 7 (OR, iswb=1) emerges.
- FIFO holds 2 entries, stall=1 for 3 cycles with out_ready=1 → out_valid=0, no pops, pushes still accepted. Release stall → entries emerge in original order.
- Push 3 entries, assert reset=0 asynchronously mid-cycle → outputs clear immediately, fifo_count=0. After release, a new MUL push gives opcode 2 with no stale data.
- Force 256 illegal requests (CNT_W=8) → illegal_cnt saturates at 255 and does not wrap.
